// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   localparam int unsigned FETCH_XLEN = 32;
   localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

   typedef struct packed {
      logic [FETCH_XLEN-1:0] pc;
      logic [31:0]           instr;
   } fetch_entry_t;

   typedef enum logic {
      RUN,
      FLUSH
   } fetch_state_e;

endpackage

// File: rtl/fetch_if.sv
// Instruction memory request/grant + in-order response-valid handshake.
interface fetch_if #(
   parameter int unsigned XLEN = 32
);
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_gnt;
   logic            imem_rvalid;
   logic [31:0]     imem_rdata;

   modport master (
      output imem_req, imem_addr,
      input  imem_gnt, imem_rvalid, imem_rdata
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_gnt, imem_rvalid, imem_rdata
   );
endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO with flush; head is read combinationally from the registered array.
module fetch_queue #(
   parameter int unsigned DEPTH = 2,
   parameter type entry_t = logic [31:0],
   localparam int unsigned PW = $clog2(DEPTH),
   localparam int unsigned CW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  entry_t        din,
   input  logic          pop,
   input  logic          flush,
   output logic [CW-1:0] count,
   output entry_t        head
);

   entry_t        mem_q [DEPTH];
   entry_t        mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push_ok, pop_ok;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      pop_ok   = pop && (count_q != '0);
      // A full queue still accepts a push when the head leaves in the same cycle.
      push_ok  = push && ((count_q != CW'(DEPTH)) || pop_ok);
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PW'(1);
         end
         if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         if (push_ok && !pop_ok) begin
            count_d = count_q + CW'(1);
         end else if (pop_ok && !push_ok) begin
            count_d = count_q - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues in-order imem requests, buffers {pc, instr} for decode.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned     XLEN     = FETCH_XLEN,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int unsigned     QDEPTH   = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en_fetch,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   fetch_if.master         imem,
   output logic            if_valid,
   output logic [31:0]     if_instr,
   output logic [XLEN-1:0] if_pc
);

   localparam int unsigned CW = $clog2(QDEPTH + 1);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [CW-1:0]   out_cnt_q, out_cnt_d;
   logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

   logic [CW-1:0]   q_count;
   logic [CW-1:0]   tag_count_unused;
   fetch_entry_t    q_head;
   fetch_entry_t    iq_din;
   logic [XLEN-1:0] tag_head;
   logic [CW:0]     occupancy;
   logic            rsp_ok, keep, pop, grant, req;

   always_comb begin
      rsp_ok    = imem.imem_rvalid && (out_cnt_q != '0);
      keep      = rsp_ok && (drop_cnt_q == '0) && !redirect;
      pop       = en_fetch && if_valid && !redirect;
      occupancy = {1'b0, out_cnt_q} + {1'b0, q_count} - {{CW{1'b0}}, pop};
      req       = (state_q == RUN) && !redirect && !rst && (occupancy < (CW+1)'(QDEPTH));
      grant     = req && imem.imem_gnt;
      iq_din       = '0;
      iq_din.pc    = tag_head;
      iq_din.instr = imem.imem_rdata;
   end

   always_comb begin
      imem.imem_req  = req;
      imem.imem_addr = pc_q;
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      out_cnt_d  = out_cnt_q;
      drop_cnt_d = drop_cnt_q;
      if (redirect) begin
         // Everything still outstanding after this cycle's response becomes stale.
         pc_d       = redirect_pc & ~XLEN'(3);
         out_cnt_d  = out_cnt_q - CW'(rsp_ok);
         drop_cnt_d = out_cnt_q - CW'(rsp_ok);
         state_d    = (drop_cnt_d != '0) ? FLUSH : RUN;
      end else begin
         if (grant) begin
            pc_d = pc_q + XLEN'(4);
         end
         if (grant && !rsp_ok) begin
            out_cnt_d = out_cnt_q + CW'(1);
         end else if (rsp_ok && !grant) begin
            out_cnt_d = out_cnt_q - CW'(1);
         end
         if (rsp_ok && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
         end
         if ((state_q == FLUSH) && (drop_cnt_d == '0)) begin
            state_d = RUN;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RUN;
         pc_q       <= RESET_PC;
         out_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         out_cnt_q  <= out_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Tags of stale requests are flushed on redirect, so only kept responses pop a tag.
   fetch_queue #(
      .DEPTH   (QDEPTH),
      .entry_t (logic [XLEN-1:0])
   ) u_tag_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (grant),
      .din   (pc_q),
      .pop   (keep),
      .flush (redirect),
      .count (tag_count_unused),
      .head  (tag_head)
   );

   fetch_queue #(
      .DEPTH   (QDEPTH),
      .entry_t (fetch_entry_t)
   ) u_instr_queue (
      .clk   (clk),
      .rst   (rst),
      .push  (keep),
      .din   (iq_din),
      .pop   (pop),
      .flush (redirect),
      .count (q_count),
      .head  (q_head)
   );

   always_comb begin
      if_valid = (q_count != '0);
      if_instr = if_valid ? q_head.instr : NOP_INSTR;
      if_pc    = if_valid ? q_head.pc : '0;
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed + randomized bench for fetch_unit against a queue-based reference model.
module tb_fetch_unit;
   import fetch_pkg::*;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned QDEPTH   = 2;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic        clk = 1'b0;
   logic        rst, en_fetch, redirect;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic [31:0] if_instr, if_pc;

   fetch_if #(.XLEN(XLEN)) imem ();

   fetch_unit #(
      .XLEN     (XLEN),
      .RESET_PC (RESET_PC),
      .QDEPTH   (QDEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en_fetch    (en_fetch),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem        (imem),
      .if_valid    (if_valid),
      .if_instr    (if_instr),
      .if_pc       (if_pc)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] addr; int unsigned due; } mreq_t;
   typedef struct { logic [31:0] pc; bit stale; } out_t;
   typedef struct { logic [31:0] pc; logic [31:0] instr; } buf_t;

   mreq_t       mem_q[$];
   out_t        m_out[$];
   buf_t        m_buf[$];
   logic [31:0] m_pc;
   int unsigned cyc, lat_lo, lat_hi;
   int          checks, errors;

   function automatic logic [31:0] mem_word(logic [31:0] a);
      return {a[15:0] ^ 16'h5A3C, ~a[17:2]};
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   task automatic step(bit r, bit en, bit rd, logic [31:0] rpc, bit g);
      bit          rv, any_stale, pop, exp_req, dut_grant;
      logic [31:0] rdata, gaddr;
      out_t        o;
      rst         = r;
      en_fetch    = en;
      redirect    = rd;
      redirect_pc = rpc;
      imem.imem_gnt = g;
      rv    = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
      rdata = rv ? mem_word(mem_q[0].addr) : 32'hDEAD_BEEF;
      imem.imem_rvalid = rv;
      imem.imem_rdata  = rdata;

      any_stale = 1'b0;
      foreach (m_out[i]) if (m_out[i].stale) any_stale = 1'b1;
      pop     = en && (m_buf.size() != 0) && !rd;
      exp_req = !r && !rd && !any_stale &&
                ((m_out.size() + m_buf.size() - int'(pop)) < int'(QDEPTH));
      #1;
      chk("imem_req", {31'b0, imem.imem_req}, {31'b0, exp_req});
      if (exp_req) chk("imem_addr", imem.imem_addr, m_pc);
      dut_grant = imem.imem_req && g;
      gaddr     = imem.imem_addr;

      @(posedge clk);
      if (r) begin
         mem_q.delete();
         m_out.delete();
         m_buf.delete();
         m_pc = RESET_PC;
      end else begin
         if (rv) void'(mem_q.pop_front());
         if (dut_grant) mem_q.push_back('{gaddr, cyc + $urandom_range(lat_hi, lat_lo)});
         if (rd) begin
            if (rv && m_out.size() != 0) void'(m_out.pop_front());
            foreach (m_out[i]) m_out[i].stale = 1'b1;
            m_buf.delete();
            m_pc = rpc & ~32'd3;
         end else begin
            if (pop) void'(m_buf.pop_front());
            if (rv && m_out.size() != 0) begin
               o = m_out.pop_front();
               if (!o.stale) m_buf.push_back('{o.pc, rdata});
            end
            if (exp_req && g) begin
               m_out.push_back('{m_pc, 1'b0});
               m_pc = m_pc + 32'd4;
            end
         end
      end
      cyc++;
      #1;
      if (m_buf.size() != 0) begin
         chk("if_valid", {31'b0, if_valid}, 32'd1);
         chk("if_instr", if_instr, m_buf[0].instr);
         chk("if_pc", if_pc, m_buf[0].pc);
      end else begin
         chk("if_valid", {31'b0, if_valid}, 32'd0);
         chk("if_instr_empty", if_instr, NOP_INSTR);
         chk("if_pc_empty", if_pc, 32'd0);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cyc    = 0;
      lat_lo = 1;
      lat_hi = 1;
      m_pc   = RESET_PC;
      rst = 1'b1; en_fetch = 1'b0; redirect = 1'b0; redirect_pc = '0;
      imem.imem_gnt = 1'b0; imem.imem_rvalid = 1'b0; imem.imem_rdata = '0;

      // Reset state
      repeat (3) step(1, 1, 0, 0, 1);
      chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
      chk("rst_if_instr", if_instr, 32'h0000_0013);
      chk("rst_if_pc", if_pc, 32'd0);

      // Streaming with k=1, decode always accepting
      repeat (12) step(0, 1, 0, 0, 1);

      // Decode stall then resume
      repeat (5) step(0, 0, 0, 0, 1);
      repeat (6) step(0, 1, 0, 0, 1);

      // Redirect to 0x103 with two requests outstanding, k=3
      lat_lo = 3; lat_hi = 3;
      repeat (2) step(1, 1, 0, 0, 1);
      repeat (2) step(0, 1, 0, 0, 1);
      step(0, 1, 1, 32'h103, 1);
      repeat (8) step(0, 1, 0, 0, 1);

      // Redirect coinciding with a response while decode accepts
      lat_lo = 1; lat_hi = 1;
      repeat (2) step(1, 1, 0, 0, 1);
      repeat (4) step(0, 1, 0, 0, 1);
      step(0, 1, 1, 32'h40, 1);
      repeat (4) step(0, 1, 0, 0, 1);

      // Grant withheld for 4 cycles
      repeat (4) step(0, 1, 0, 0, 0);
      repeat (4) step(0, 1, 0, 0, 1);

      // Reset while flushing stale responses
      lat_lo = 3; lat_hi = 3;
      repeat (2) step(1, 1, 0, 0, 1);
      repeat (2) step(0, 1, 0, 0, 1);
      step(0, 1, 1, 32'h200, 1);
      step(0, 1, 0, 0, 1);
      step(1, 1, 0, 0, 1);
      repeat (6) step(0, 1, 0, 0, 1);

      // Randomized traffic
      lat_lo = 1; lat_hi = 4;
      repeat (500) begin
         step(($urandom % 100) == 0, ($urandom % 4) != 0, ($urandom % 20) == 0,
              $urandom, ($urandom % 3) != 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
